data_memory_sync: RTL

//  Clocked, parametrised successor of the combinational data memory in the MEM stage.

---
 rtl/data_memory_sync_if.sv | 29 ++
 rtl/data_memory_sync.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_memory_sync_if.sv
// Request/response bundle between a MEM-stage master and data_memory_sync.
// Handshake: a request (d_re and/or d_we with d_addr/d_be/d_wdata) is sampled on
// every rising clk edge while d_busy is low; there is no back-pressure, so the
// master must treat d_busy as "not ready" and expect dropped requests while it
// is high. d_valid/d_err are one-cycle responses to the request sampled one
// edge earlier.
interface data_memory_sync_if #(
    parameter int DW = 16
);
    logic [15:0]     d_addr;
    logic            d_re;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_wdata;
    logic [DW-1:0]   d_dataout;
    logic            d_valid;
    logic            d_err;
    logic            d_busy;

    modport master (
        output d_addr, d_re, d_we, d_be, d_wdata,
        input  d_dataout, d_valid, d_err, d_busy
    );

    modport slave (
        input  d_addr, d_re, d_we, d_be, d_wdata,
        output d_dataout, d_valid, d_err, d_busy
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked data memory for the MEM stage: DEPTH x DW words, byte strobes,
// registered 1-cycle read, write-first on same-index read/write, range
// checking instead of aliasing, and a reset-time sweep that loads the
// array with the ALU test vectors (or zeros).
module data_memory_sync #(
    parameter int DW      = 16,
    parameter int DEPTH   = 16,
    parameter int PRELOAD = 1
) (
    input  logic                 clk,
    input  logic                 r_st,
    data_memory_sync_if.slave    bus,
    output logic                 dbg_state   // 0: INIT sweep, 1: READY
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DW / 8;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [DW-1:0]   mem_wdata;

    logic [AW-1:0]   req_idx;
    logic            req_oor;
    logic [DW-1:0]   old_word;
    logic [DW-1:0]   merged_word;

    // Value the sweep loads into word idx.
    function automatic logic [DW-1:0] preload_word(input logic [AW-1:0] idx);
        logic [DW-1:0] w;
        w = '0;
        if (PRELOAD != 0) begin
            case (idx)
                AW'(0):  w = DW'(16'h3c00);
                AW'(1):  w = DW'(16'hffff);
                AW'(2):  w = DW'(16'h3cab);
                AW'(3):  w = DW'(16'haaaa);
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // Address decode and byte-strobe merge of the addressed word.
    always_comb begin
        req_idx     = bus.d_addr[AW-1:0];
        req_oor     = ({1'b0, bus.d_addr} >= DEPTH_L);
        old_word    = mem_q[req_idx];
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.d_be[i]) begin
                merged_word[8*i +: 8] = bus.d_wdata[8*i +: 8];
            end
        end
    end

    // Next-state logic: init sweep, then request servicing in READY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = ptr_q;
        mem_wdata = preload_word(ptr_q);

        case (state_q)
            ST_INIT: begin
                // Requests are ignored while sweeping.
                mem_we = 1'b1;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                if (bus.d_re || bus.d_we) begin
                    if (req_oor) begin
                        dataout_d = '0;
                        err_d     = 1'b1;
                        valid_d   = bus.d_re;
                    end else begin
                        if (bus.d_we) begin
                            mem_we    = 1'b1;
                            mem_idx   = req_idx;
                            mem_wdata = merged_word;
                        end
                        if (bus.d_re) begin
                            // Write-first: a same-cycle write is visible in the read data.
                            dataout_d = bus.d_we ? merged_word : old_word;
                            valid_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control and output registers, asynchronously reset into the sweep.
    always_ff @(posedge clk or negedge r_st) begin
        if (!r_st) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            busy_q    <= 1'b1;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Storage array: synchronous write only, never touched by the async reset.
    always_ff @(posedge clk) begin
        if (mem_we && r_st) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign bus.d_dataout = dataout_q;
    assign bus.d_valid   = valid_q;
    assign bus.d_err     = err_q;
    assign bus.d_busy    = busy_q;
    assign dbg_state     = (state_q == ST_READY);
endmodule
